// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle processor: opcodes, sequencer states,
// next-PC select codes and the end-of-instruction decode.
package mc_pkg;

   localparam logic [5:0] OP_AND    = 6'd0;
   localparam logic [5:0] OP_ADD    = 6'd1;
   localparam logic [5:0] OP_SUB    = 6'd2;
   localparam logic [5:0] OP_ANDI   = 6'd3;
   localparam logic [5:0] OP_ADDI   = 6'd4;
   localparam logic [5:0] OP_LW     = 6'd5;
   localparam logic [5:0] OP_LW_POI = 6'd6;
   localparam logic [5:0] OP_SW     = 6'd7;
   localparam logic [5:0] OP_BGT    = 6'd8;
   localparam logic [5:0] OP_BLT    = 6'd9;
   localparam logic [5:0] OP_BEQ    = 6'd10;
   localparam logic [5:0] OP_BNE    = 6'd11;
   localparam logic [5:0] OP_JMP    = 6'd12;
   localparam logic [5:0] OP_CALL   = 6'd13;
   localparam logic [5:0] OP_RET    = 6'd14;
   localparam logic [5:0] OP_PUSH   = 6'd15;
   localparam logic [5:0] OP_POP    = 6'd16;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4
   } state_e;

   localparam logic [1:0] PC_INC = 2'd0;
   localparam logic [1:0] PC_J26 = 2'd1;
   localparam logic [1:0] PC_B16 = 2'd2;
   localparam logic [1:0] PC_RET = 2'd3;

   // WB is terminal for every path that reaches it; FETCH never is.
   function automatic logic last_state(input logic [5:0] opcode, input state_e state);
      logic v_last;
      v_last = 1'b0;
      case (state)
         ST_DECODE: v_last = (opcode == OP_JMP) || (opcode > OP_POP);
         ST_EXEC:   v_last = (opcode >= OP_BGT) && (opcode <= OP_BNE);
         ST_MEM:    v_last = (opcode == OP_SW) || (opcode == OP_CALL) || (opcode == OP_PUSH);
         ST_WB:     v_last = 1'b1;
         default:   v_last = 1'b0;
      endcase
      return v_last;
   endfunction

endpackage

// File: rtl/next_pc_logic.sv
// Next-PC selection: increment, PC-relative jump/branch offsets, or return address.
module next_pc_logic
   import mc_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [15:0] imm16,
   input  logic [25:0] imm26,
   input  logic [31:0] ret_addr,
   input  logic [1:0]  pc_src,
   output logic [31:0] next_pc,
   output logic [31:0] pc_plus1
);

   logic [31:0] w_sext16;
   logic [31:0] w_sext26;

   assign w_sext16 = {{16{imm16[15]}}, imm16};
   assign w_sext26 = {{6{imm26[25]}}, imm26};
   assign pc_plus1 = pc + 32'd1;

   always_comb begin
      next_pc = pc_plus1;
      case (pc_src)
         PC_INC:  next_pc = pc_plus1;
         PC_J26:  next_pc = pc + w_sext26;
         PC_B16:  next_pc = pc + w_sext16;
         PC_RET:  next_pc = ret_addr;
         default: next_pc = pc_plus1;
      endcase
   end

endmodule

// File: rtl/multicycle_sequencer.sv
// Fetch/sequencing stage: PC, IR, field split and the per-instruction stage FSM.
//
//   state  | meaning
//   FETCH  | inst_in valid at pc; IR loads on exit
//   DECODE | fields valid; JMP and NOP finish here
//   EXEC   | ALU cycle; branches finish here
//   MEM    | data-memory access; SW, CALL, PUSH finish here
//   WB     | register write-back / RET, POP read data valid
module multicycle_sequencer
   import mc_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'd0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] inst_in,
   input  logic [1:0]  pc_src,
   input  logic [31:0] ret_addr,
   output logic [31:0] pc,
   output logic [31:0] pc_plus1,
   output logic [31:0] ir,
   output logic [5:0]  opcode,
   output logic [3:0]  rd,
   output logic [3:0]  rs1,
   output logic [3:0]  rs2,
   output logic [15:0] imm16,
   output logic [1:0]  mode,
   output logic [25:0] imm26,
   output logic        st_fetch,
   output logic        st_decode,
   output logic        st_exec,
   output logic        st_mem,
   output logic        st_wb,
   output logic        inst_done,
   output logic [31:0] retired
);

   state_e      r_state;
   state_e      w_next_state;
   logic [31:0] r_pc;
   logic [31:0] r_ir;
   logic [31:0] r_retired;
   logic [31:0] w_next_pc;
   logic [1:0]  w_pc_src;
   logic        w_last;

   assign pc      = r_pc;
   assign ir      = r_ir;
   assign retired = r_retired;
   assign opcode  = r_ir[31:26];
   assign rd      = r_ir[25:22];
   assign rs1     = r_ir[21:18];
   assign rs2     = r_ir[17:14];
   assign imm16   = r_ir[17:2];
   assign mode    = r_ir[1:0];
   assign imm26   = r_ir[25:0];

   assign st_fetch  = (r_state == ST_FETCH);
   assign st_decode = (r_state == ST_DECODE);
   assign st_exec   = (r_state == ST_EXEC);
   assign st_mem    = (r_state == ST_MEM);
   assign st_wb     = (r_state == ST_WB);

   // In FETCH the IR still holds the previous instruction, which last_state ignores.
   assign w_last    = last_state(opcode, r_state);
   assign inst_done = w_last;

   // Undefined opcodes always fall through to the next word.
   assign w_pc_src = (opcode > OP_POP) ? PC_INC : pc_src;

   next_pc_logic u_next_pc (
      .pc       (r_pc),
      .imm16    (imm16),
      .imm26    (imm26),
      .ret_addr (ret_addr),
      .pc_src   (w_pc_src),
      .next_pc  (w_next_pc),
      .pc_plus1 (pc_plus1)
   );

   always_comb begin
      w_next_state = r_state;
      if (w_last) begin
         w_next_state = ST_FETCH;
      end else begin
         case (r_state)
            ST_FETCH:  w_next_state = ST_DECODE;
            ST_DECODE: w_next_state = (opcode == OP_CALL || opcode == OP_RET ||
                                       opcode == OP_PUSH || opcode == OP_POP) ? ST_MEM : ST_EXEC;
            ST_EXEC:   w_next_state = (opcode == OP_LW || opcode == OP_LW_POI ||
                                       opcode == OP_SW) ? ST_MEM : ST_WB;
            ST_MEM:    w_next_state = ST_WB;
            default:   w_next_state = ST_FETCH;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_FETCH;
         r_pc      <= RESET_PC;
         r_ir      <= 32'd0;
         r_retired <= 32'd0;
      end else begin
         r_state <= w_next_state;
         if (r_state == ST_FETCH) begin
            r_ir <= inst_in;
         end
         if (w_last) begin
            r_pc      <= w_next_pc;
            r_retired <= r_retired + 32'd1;
         end
      end
   end

endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Fetch and sequencing stage for the multi-cycle processor. Holds the PC and instruction register (IR), drives the instruction-memory address, and splits each instruction into fields. A 5-state FSM advances each instruction through only the stages it needs and emits one-hot stage strobes to gate the register file, ALU, data memory and write-back. The combinational control unit consumes `opcode`; this block computes the next PC from that unit's `pc_src`.

## Interface
- `RESET_PC`, default 0: PC value after reset (word address).
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `inst_in`  in  32  instruction read combinationally from instruction memory at `pc`.
- `pc_src`  in  2  next-PC select from the control unit:
  - 0: PC+1
  - 1: PC+sext(imm26)
  - 2: PC+sext(imm16)
  - 3: `ret_addr`
- `ret_addr`  in  32  data-memory read data; used when `pc_src`=3.
- `pc`  out  32  current PC (instruction-memory address); reset `RESET_PC`.
- `pc_plus1`  out  32  `pc`+1, used as CALL push data; reset `RESET_PC`+1.
- `ir`  out  32  latched instruction; reset 0.
- `opcode`  out  6  `ir[31:26]`.
- `rd`, `rs1`, `rs2`  out  4 each  `ir[25:22]`, `ir[21:18]`, `ir[17:14]`.
- `imm16`  out  16  `ir[17:2]`.
- `mode`  out  2  `ir[1:0]`.
- `imm26`  out  26  `ir[25:0]`.
- `st_fetch`, `st_decode`, `st_exec`, `st_mem`, `st_wb`  out  1 each  one-hot state strobes. Reset value: `st_fetch`=1, all others 0.
- `inst_done`  out  1  high during the final state of an instruction; reset 0.
- `retired`  out  32  count of completed instructions; reset 0.

## Operation
- FSM states: FETCH, DECODE, EXEC, MEM, WB. Every instruction starts in FETCH; DECODE always follows.
- IR loads `inst_in` on the edge leaving FETCH. IR is otherwise held.
- Path through the states after DECODE, by opcode:
  - AND, ADD, SUB, ANDI, ADDI: EXEC -> WB.
  - LW (000101), LW_POI (000110): EXEC -> MEM -> WB.
  - SW (000111): EXEC -> MEM.
  - BGT, BLT, BEQ, BNE (001000–001011): EXEC.
  - JMP (001100): ends in DECODE.
  - CALL (001101), PUSH (001111): MEM.
  - RET (001110), POP (010000): MEM -> WB. The data-memory read is issued in MEM and its result is valid in WB.
  - Any opcode above 010000 is a NOP that ends in DECODE, with PC+1.
- `inst_done` is asserted in the final state of the instruction's path. On the edge ending that state:
  - PC loads the next PC selected by the `pc_src` value sampled in that cycle.
  - `retired` increments.
  - The FSM returns to FETCH.
- Arithmetic is 32-bit modulo 2^32:
  - PC+1 wraps from FFFFFFFF to 0.
  - sext(imm26) and sext(imm16) are two's complement; offsets are relative to the current PC.
  - `retired` wraps.
- `pc_src` is ignored in every non-final state. PC is held everywhere except on the commit edge.
- When `rst_n` goes low, even mid-instruction, the block immediately returns to its reset values: FETCH, PC=`RESET_PC`, IR=0, `retired`=0. The interrupted instruction does not commit. The first FETCH begins on the first rising edge after `rst_n` deasserts.

## Timing
- Latency per instruction, in cycles:
  - JMP and NOP: 2.
  - Branch, CALL, PUSH: 3.
  - ALU ops, SW, RET, POP: 4.
  - LW, LW_POI: 5.
- All outputs are registered or decoded directly from registers. There is no combinational path from `pc_src` or `ret_addr` to any output.
- `ret_addr` only needs to be stable in the WB cycle of RET.
- Exactly one `st_*` strobe is high in any cycle.

## Structure
- The shared package `mc_pkg` holds:
  - opcode constants AND..POP,
  - the state enum (FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4),
  - the `pc_src` encoding constants,
  - a function `last_state(opcode, state)` that returns the final-state flag.
- One combinational sub-module, `next_pc_logic`, has inputs `pc`, `imm16`, `imm26`, `ret_addr` and `pc_src`, and outputs `next_pc` and `pc_plus1`.

## Test plan
- Reset, then instruction memory holds 090C8000 (SUB) at 0:
  - strobes run F, D, E, W;
  - `rd`=4, `rs1`=3, `rs2`=2;
  - `inst_done` is high in cycle 4;
  - afterwards PC=1 and `retired`=1.
- LW 158C0010 at PC 2 with `pc_src`=0:
  - strobes run F, D, E, M, W;
  - `imm16`=4, `mode`=0;
  - PC=3 after 5 cycles.
- JMP 33FFFFFD at PC 5 with `pc_src`=1: after 2 cycles PC=2, and `st_exec` never asserts.
- BEQ with imm16=FFFE at PC 10:
  - `pc_src`=2 in EXEC gives PC=8 after 3 cycles;
  - repeated with `pc_src`=0, PC=11.
- RET at PC 7 with `ret_addr`=0x00000004 in WB and `pc_src`=3: PC=4 after 4 cycles. CALL at PC 6: `pc_plus1`=7 throughout.
- `rst_n` pulsed low during MEM of LW_POI at PC 3:
  - immediately FETCH, PC=0, IR=0, `retired`=0, `inst_done`=0;
  - with opcode 3F the block runs 2 cycles and PC becomes +1.
